// File: rtl/mem_loader_pkg.sv
// -----------------------------------------------------------------------------
// mem_loader_pkg
// Shared definitions for the program loader. These are the machine-wide widths,
// the default program base address, and the loader state encoding.
// -----------------------------------------------------------------------------
package mem_loader_pkg;

    localparam int ADDR_WIDTH = 16;
    localparam int REG_WIDTH  = 8;
    localparam int LDR_CSUM_W = 8;

    // Default load address of the program image.
    localparam logic [ADDR_WIDTH-1:0] INSTRUCTION_BASE = 16'h0200;

    typedef enum logic [2:0] {
        LDR_IDLE    = 3'd0,
        LDR_LOAD    = 3'd1,
        LDR_VFY_RD  = 3'd2,
        LDR_VFY_CMP = 3'd3,
        LDR_LAUNCH  = 3'd4,
        LDR_RUN     = 3'd5,
        LDR_ERROR   = 3'd6
    } ldr_state_e;

endpackage

// File: rtl/mem_loader_addr_gen.sv
// -----------------------------------------------------------------------------
// ldr_addr_gen
// Pointer and remaining-count pair. The LOAD pass (writes) and the VFY_RD pass
// (reads) both walk the same region, so they share this counter.
//   load_i  : ptr <= base_i, remaining <= count_i (wins over step_i)
//   step_i  : ptr <= ptr + 1 (wraps mod 2^ADDR_W), remaining <= remaining - 1
//   ptr_o   : current address
//   last_o  : the current address is the final one of the region
// -----------------------------------------------------------------------------
module ldr_addr_gen
    import mem_loader_pkg::*;
#(
    parameter int ADDR_W = ADDR_WIDTH
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load_i,
    input  logic              step_i,
    input  logic [ADDR_W-1:0] base_i,
    input  logic [ADDR_W-1:0] count_i,
    output logic [ADDR_W-1:0] ptr_o,
    output logic              last_o
);

    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W-1:0] rem_q, rem_d;

    // NOTE: every combinational output is given a default before any branch,
    // so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        ptr_d = ptr_q;
        rem_d = rem_q;
        if (load_i) begin
            ptr_d = base_i;
            rem_d = count_i;
        end else if (step_i) begin
            ptr_d = ptr_q + 1'b1;
            rem_d = rem_q - 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples its next value from the same pre-edge snapshot.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ptr_q <= '0;
            rem_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            rem_q <= rem_d;
        end
    end

    assign ptr_o  = ptr_q;
    assign last_o = (rem_q == ADDR_W'(1));

endmodule

// File: rtl/mem_loader.sv
// -----------------------------------------------------------------------------
// mem_loader
// Program loader. It owns the memory port while the CPU is held in reset. It
// streams bytes into sequential addresses and optionally reads the region back
// to compare an additive checksum. It then hands the port to the CPU, releases
// CPU reset and pulses trigger_program.
// Ports:
//   clk, reset_n          : clock (same as mem), synchronous active-low reset
//   start                 : one-cycle load request (base_addr/length sampled)
//   s_valid/s_data/s_ready: byte stream handshake
//   mem_sel/we/addr/din   : memory port drive (mem_sel=1 -> loader owns port)
//   mem_dout              : memory read data, one cycle after mem_addr
//   cpu_reset_n           : CPU reset, released on launch
//   trigger_program       : one-cycle launch pulse
//   busy, error, checksum : status
// -----------------------------------------------------------------------------
module mem_loader
    import mem_loader_pkg::*;
#(
    parameter int ADDR_W = ADDR_WIDTH,
    parameter int DATA_W = REG_WIDTH,
    parameter bit VERIFY = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] length,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic              mem_sel,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout,
    output logic              cpu_reset_n,
    output logic              trigger_program,
    output logic              busy,
    output logic              error,
    output logic [DATA_W-1:0] checksum
);

    ldr_state_e        state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_din_q, mem_din_d;
    logic [DATA_W-1:0] csum_q, csum_d;
    logic [DATA_W-1:0] vsum_q, vsum_d;
    logic              error_q, error_d;
    // Read pipeline tags: rd_v1 = mem_addr holds a verify address,
    // rd_v2 = mem_dout holds that address's data.
    logic              rd_v1_q, rd_v1_d;
    logic              rd_v2_q, rd_v2_d;

    logic              gen_load, gen_step, gen_last;
    logic [ADDR_W-1:0] gen_base, gen_count, gen_ptr;

    ldr_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .load_i  (gen_load),
        .step_i  (gen_step),
        .base_i  (gen_base),
        .count_i (gen_count),
        .ptr_o   (gen_ptr),
        .last_o  (gen_last)
    );

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        len_d      = len_q;
        mem_we_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        mem_din_d  = mem_din_q;
        csum_d     = csum_q;
        vsum_d     = vsum_q;
        error_d    = error_q;
        rd_v1_d    = 1'b0;
        rd_v2_d    = rd_v1_q;
        gen_load   = 1'b0;
        gen_step   = 1'b0;
        gen_base   = base_addr;
        gen_count  = length;

        if (rd_v2_q) begin
            vsum_d = vsum_q + mem_dout;
        end

        unique case (state_q)
            LDR_IDLE, LDR_RUN, LDR_ERROR: begin
                if (start) begin
                    base_d   = base_addr;
                    len_d    = length;
                    csum_d   = '0;
                    error_d  = 1'b0;
                    gen_load = 1'b1;
                    state_d  = (length == '0) ? LDR_LAUNCH : LDR_LOAD;
                end
            end
            LDR_LOAD: begin
                // s_ready is high throughout LOAD, so s_valid alone is the handshake.
                if (s_valid) begin
                    mem_we_d   = 1'b1;
                    mem_addr_d = gen_ptr;
                    mem_din_d  = s_data;
                    csum_d     = csum_q + s_data;
                    gen_step   = 1'b1;
                    if (gen_last) begin
                        if (VERIFY) begin
                            gen_load  = 1'b1;
                            gen_base  = base_q;
                            gen_count = len_q;
                            vsum_d    = '0;
                            state_d   = LDR_VFY_RD;
                        end else begin
                            // One cycle in VFY_CMP lets the final registered
                            // write land before the port is handed over.
                            state_d = LDR_VFY_CMP;
                        end
                    end
                end
            end
            LDR_VFY_RD: begin
                // The first issue cycle coincides with the final write's
                // mem_we, so that write lands before any read.
                mem_addr_d = gen_ptr;
                rd_v1_d    = 1'b1;
                gen_step   = 1'b1;
                if (gen_last) begin
                    state_d = LDR_VFY_CMP;
                end
            end
            LDR_VFY_CMP: begin
                if (!VERIFY) begin
                    state_d = LDR_LAUNCH;
                end else if (!rd_v1_q && !rd_v2_q) begin
                    // Compare only after the in-flight reads have drained.
                    if (vsum_q == csum_q) begin
                        state_d = LDR_LAUNCH;
                    end else begin
                        error_d = 1'b1;
                        state_d = LDR_ERROR;
                    end
                end
            end
            LDR_LAUNCH: state_d = LDR_RUN;
            default:    state_d = LDR_IDLE;
        endcase
    end

    // NOTE: reset is synchronous. It is sampled only on the clock edge and
    // overrides any start that arrives in the same cycle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= LDR_IDLE;
            base_q     <= '0;
            len_q      <= '0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
            csum_q     <= '0;
            vsum_q     <= '0;
            error_q    <= 1'b0;
            rd_v1_q    <= 1'b0;
            rd_v2_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            len_q      <= len_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_din_q  <= mem_din_d;
            csum_q     <= csum_d;
            vsum_q     <= vsum_d;
            error_q    <= error_d;
            rd_v1_q    <= rd_v1_d;
            rd_v2_q    <= rd_v2_d;
        end
    end

    assign s_ready         = (state_q == LDR_LOAD);
    assign cpu_reset_n     = (state_q == LDR_LAUNCH) || (state_q == LDR_RUN);
    assign mem_sel         = !cpu_reset_n;
    assign trigger_program = (state_q == LDR_LAUNCH);
    assign busy            = (state_q == LDR_LOAD) || (state_q == LDR_VFY_RD) ||
                             (state_q == LDR_VFY_CMP);
    assign error           = error_q;
    assign checksum        = csum_q;
    assign mem_we          = mem_we_q;
    assign mem_addr        = mem_addr_q;
    assign mem_din         = mem_din_q;

endmodule

// File: tb/tb_mem_loader.sv
// -----------------------------------------------------------------------------
// tb_mem_loader
// Self-checking bench for mem_loader. It contains a behavioural memory with a
// one-cycle read latency. Expected writes, checksum and launch/error outcome
// are derived from the byte list given to each load.
// -----------------------------------------------------------------------------
module tb_mem_loader;
    import mem_loader_pkg::*;

    localparam int AW = ADDR_WIDTH;
    localparam int DW = REG_WIDTH;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW-1:0] length;
    logic          s_valid;
    logic [DW-1:0] s_data;
    logic          s_ready;
    logic          mem_sel;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic [DW-1:0] mem_dout;
    logic          cpu_reset_n;
    logic          trigger_program;
    logic          busy;
    logic          error;
    logic [DW-1:0] checksum;

    always #5 clk = ~clk;

    mem_loader #(.ADDR_W(AW), .DATA_W(DW), .VERIFY(1'b1)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .start           (start),
        .base_addr       (base_addr),
        .length          (length),
        .s_valid         (s_valid),
        .s_data          (s_data),
        .s_ready         (s_ready),
        .mem_sel         (mem_sel),
        .mem_we          (mem_we),
        .mem_addr        (mem_addr),
        .mem_din         (mem_din),
        .mem_dout        (mem_dout),
        .cpu_reset_n     (cpu_reset_n),
        .trigger_program (trigger_program),
        .busy            (busy),
        .error           (error),
        .checksum        (checksum)
    );

    // Behavioural memory: write on the edge, registered read data.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic          corrupt_en   = 1'b0;
    logic [AW-1:0] corrupt_addr = '0;

    always @(posedge clk) begin
        if (mem_sel && mem_we) mem[mem_addr] <= mem_din;
        if (corrupt_en) mem[corrupt_addr] <= 8'hFF;
        mem_dout <= mem[mem_addr];
    end

    // Monitor: log every loader write and count launch pulses.
    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;
    wr_t wr_q[$];
    int  trig_cnt = 0;

    always @(negedge clk) begin
        if (reset_n && mem_sel && mem_we) wr_q.push_back({mem_addr, mem_din});
        if (trigger_program) trig_cnt++;
    end

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_mem_sel"},     32'(mem_sel), 32'd1);
        check({tag, "_cpu_reset_n"}, 32'(cpu_reset_n), 32'd0);
        check({tag, "_mem_we"},      32'(mem_we), 32'd0);
        check({tag, "_mem_addr"},    32'(mem_addr), 32'd0);
        check({tag, "_mem_din"},     32'(mem_din), 32'd0);
        check({tag, "_s_ready"},     32'(s_ready), 32'd0);
        check({tag, "_trigger"},     32'(trigger_program), 32'd0);
        check({tag, "_busy"},        32'(busy), 32'd0);
        check({tag, "_error"},       32'(error), 32'd0);
        check({tag, "_checksum"},    32'(checksum), 32'd0);
    endtask

    // Waits (bounded) for either a launch pulse or a settled error.
    task automatic wait_outcome(output bit got_trig, output bit got_err, output int lat);
        got_trig = 1'b0;
        got_err  = 1'b0;
        lat      = 0;
        while (!got_trig && !got_err && lat < 300) begin
            if (trigger_program)      got_trig = 1'b1;
            else if (error && !busy)  got_err  = 1'b1;
            else begin
                tick();
                lat++;
            end
        end
    endtask

    // mode: 0 = s_valid held high, 1 = fixed 1,0,0,1,0,1 pattern, 2 = random.
    task automatic run_load(input string tag, input logic [AW-1:0] base,
                            input logic [DW-1:0] bytes[$], input int mode,
                            input bit corrupt, input bit poke);
        int            n   = bytes.size();
        int            wb  = wr_q.size();
        int            tb0 = trig_cnt;
        int            idx = 0;
        int            cyc = 0;
        int            lat;
        logic [DW-1:0] exp_sum = '0;
        logic [5:0]    pat = 6'b101001;
        bit            exp_ok, v, got_trig, got_err;

        foreach (bytes[i]) exp_sum += bytes[i];
        exp_ok = !(corrupt && n > 1 && bytes[1] != 8'hFF);

        start = 1'b1; base_addr = base; length = AW'(n);
        tick();
        start = 1'b0; base_addr = AW'($urandom); length = AW'($urandom);
        if (n > 0) check({tag, "_busy_after_start"}, 32'(busy), 32'd1);

        while (idx < n && cyc < 500) begin
            if (mode == 0)      v = 1'b1;
            else if (mode == 1) v = (cyc < 6) ? pat[cyc] : 1'b1;
            else                v = 1'($urandom_range(0, 1));
            s_valid = v;
            s_data  = v ? bytes[idx] : DW'($urandom);
            start   = poke && (cyc == 1);
            if (start) begin
                base_addr = base ^ AW'(16'h5555);
                length    = AW'(1);
            end
            // s_ready depends only on registered state, so it is stable here.
            if (v && s_ready) idx++;
            tick();
            cyc++;
        end
        s_valid = 1'b0;
        start   = 1'b0;
        check({tag, "_bytes_accepted"}, 32'(idx), 32'(n));

        if (corrupt) begin
            corrupt_addr = base + AW'(1);
            corrupt_en   = 1'b1;
        end
        wait_outcome(got_trig, got_err, lat);
        corrupt_en = 1'b0;
        check({tag, "_launched"}, 32'(got_trig), 32'(exp_ok));
        check({tag, "_errored"},  32'(got_err),  32'(!exp_ok));
        if (n == 0) check({tag, "_launch_latency"}, 32'(lat), 32'd0);

        if (got_trig) begin
            check({tag, "_launch_mem_sel"}, 32'(mem_sel), 32'd0);
            check({tag, "_launch_cpu_rst"}, 32'(cpu_reset_n), 32'd1);
            check({tag, "_launch_busy"},    32'(busy), 32'd0);
            tick();
            check({tag, "_run_trigger"},    32'(trigger_program), 32'd0);
            check({tag, "_run_mem_sel"},    32'(mem_sel), 32'd0);
            check({tag, "_run_cpu_rst"},    32'(cpu_reset_n), 32'd1);
        end else if (got_err) begin
            check({tag, "_err_flag"},    32'(error), 32'd1);
            check({tag, "_err_cpu_rst"}, 32'(cpu_reset_n), 32'd0);
            check({tag, "_err_mem_sel"}, 32'(mem_sel), 32'd1);
        end
        tick(2);
        check({tag, "_checksum"},  32'(checksum), 32'(exp_sum));
        check({tag, "_trig_cnt"},  32'(trig_cnt - tb0), exp_ok ? 32'd1 : 32'd0);
        check({tag, "_n_writes"},  32'(wr_q.size() - wb), 32'(n));
        for (int i = 0; i < n && (wb + i) < wr_q.size(); i++) begin
            check({tag, "_wr_addr"}, 32'(wr_q[wb + i].addr), 32'(AW'(base + AW'(i))));
            check({tag, "_wr_data"}, 32'(wr_q[wb + i].data), 32'(bytes[i]));
        end
    endtask

    initial begin
        logic [DW-1:0] bytes[$];
        logic [DW-1:0] prog[$];
        logic [AW-1:0] b;
        int            wb;

        prog = '{8'hA9, 8'h05, 8'hEA, 8'hEA};
        reset_n = 1'b0; start = 1'b0; base_addr = '0; length = '0;
        s_valid = 1'b0; s_data = '0;
        tick(3);
        check_reset_outputs("reset");
        reset_n = 1'b1;
        tick();

        // Basic load of a short program at the default base.
        run_load("basic", INSTRUCTION_BASE, prog, 0, 1'b0, 1'b0);

        // Backpressure: 3 bytes over a gapped valid pattern.
        bytes = {};
        repeat (3) bytes.push_back(DW'($urandom));
        run_load("bp", AW'($urandom), bytes, 1, 1'b0, 1'b0);

        // Verify failure, then a clean retry from ERROR.
        run_load("vfail", INSTRUCTION_BASE, prog, 0, 1'b1, 1'b0);
        run_load("retry", INSTRUCTION_BASE, prog, 0, 1'b0, 1'b0);
        check("retry_error_cleared", 32'(error), 32'd0);

        // Zero length launches without touching memory.
        bytes = {};
        run_load("zero", AW'($urandom), bytes, 0, 1'b0, 1'b0);

        // Address wrap through the top of memory.
        bytes = {};
        repeat (4) bytes.push_back(DW'($urandom));
        run_load("wrap", AW'((1 << AW) - 2), bytes, 2, 1'b0, 1'b0);

        // A start pulse during LOAD must be ignored.
        bytes = {};
        repeat (5) bytes.push_back(DW'($urandom));
        run_load("busy_start", AW'($urandom), bytes, 2, 1'b0, 1'b1);

        // A few random loads.
        for (int k = 0; k < 3; k++) begin
            bytes = {};
            repeat ($urandom_range(1, 8)) bytes.push_back(DW'($urandom));
            run_load("rand", AW'($urandom), bytes, 2, 1'b0, 1'b0);
        end

        // Reset after 2 of 4 bytes: outputs return to reset values at once.
        b  = AW'($urandom);
        wb = wr_q.size();
        start = 1'b1; base_addr = b; length = AW'(4);
        tick();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            s_valid = 1'b1; s_data = prog[i];
            tick();
        end
        s_valid = 1'b0;
        reset_n = 1'b0;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        check_reset_outputs("midreset");
        check("midreset_first_byte_kept", 32'(mem[b]), 32'(prog[0]));
        check("midreset_writes_seen", 32'(wr_q.size() - wb) >= 32'd1 ? 32'd1 : 32'd0, 32'd1);
        reset_n = 1'b1;
        tick();
        check("post_reset_idle_busy", 32'(busy), 32'd0);

        // Recovery after reset.
        run_load("recover", INSTRUCTION_BASE, prog, 2, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
